// File: rtl/icache_responder_if.sv
// Fetch-side and memory-side signals of the direct-mapped instruction cache.
interface icache_responder_if #(
    parameter int ADDR_W = 32
);
    logic              fetch2iCache_en;
    logic [ADDR_W-1:0] fetch2iCache_address;
    logic [31:0]       iCache2fetch_ins;
    logic              iCache2fetch_valid;
    logic              iCache2mem_req;
    logic [ADDR_W-1:0] iCache2mem_addr;
    logic              mem2iCache_grant;
    logic [7:0]        mem2iCache_byte;

    // Cache view: answers the fetch buffer and masters the memory request port.
    modport master (
        input  fetch2iCache_en,
        input  fetch2iCache_address,
        input  mem2iCache_grant,
        input  mem2iCache_byte,
        output iCache2fetch_ins,
        output iCache2fetch_valid,
        output iCache2mem_req,
        output iCache2mem_addr
    );

    // Peer view: the fetch buffer together with the memory controller.
    modport slave (
        output fetch2iCache_en,
        output fetch2iCache_address,
        output mem2iCache_grant,
        output mem2iCache_byte,
        input  iCache2fetch_ins,
        input  iCache2fetch_valid,
        input  iCache2mem_req,
        input  iCache2mem_addr
    );
endinterface

// File: rtl/icache_responder.sv
// Direct-mapped instruction cache with one 32-bit word per line.
// Hits answer one cycle after the request; misses refill the line byte by byte
// from a byte-serial memory controller and answer after the last byte lands.
module icache_responder #(
    parameter int INDEX_BITS = 6,
    parameter int ADDR_W     = 32
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               flush_in,
    icache_responder_if.master bus
);
    localparam int LINES  = 1 << INDEX_BITS;
    localparam int WORD_W = ADDR_W - 2;
    localparam int TAG_W  = ADDR_W - INDEX_BITS - 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_t;

    state_t              r_state,     w_state_nxt;
    logic [WORD_W-1:0]   r_word_addr, w_word_addr_nxt;
    logic [1:0]          r_cnt,       w_cnt_nxt;
    logic                r_pend,      w_pend_nxt;   // a granted byte arrives this cycle
    logic [1:0]          r_lane,      w_lane_nxt;   // lane of that byte
    logic [31:0]         r_line,      w_line_nxt;   // line under assembly
    logic [31:0]         r_ins,       w_ins_nxt;
    logic                r_valid,     w_valid_nxt;
    logic                w_wr_en;

    logic [LINES-1:0]    r_vld;
    logic [TAG_W-1:0]    r_tag  [LINES];
    logic [31:0]         r_data [LINES];

    logic [INDEX_BITS-1:0] w_lkp_index;
    logic [TAG_W-1:0]      w_lkp_tag;
    logic                  w_hit;
    logic [INDEX_BITS-1:0] w_fill_index;
    logic [TAG_W-1:0]      w_fill_tag;
    logic [31:0]           w_line_merged;
    logic                  w_req;

    assign w_lkp_index  = bus.fetch2iCache_address[INDEX_BITS+1:2];
    assign w_lkp_tag    = bus.fetch2iCache_address[ADDR_W-1:INDEX_BITS+2];
    assign w_hit        = r_vld[w_lkp_index] && (r_tag[w_lkp_index] == w_lkp_tag);
    assign w_fill_index = r_word_addr[INDEX_BITS-1:0];
    assign w_fill_tag   = r_word_addr[WORD_W-1:INDEX_BITS];

    // Drop the byte returned for the previous grant into its lane.
    always_comb begin
        w_line_merged = r_line;
        if (r_pend) begin
            w_line_merged[{r_lane, 3'b000} +: 8] = bus.mem2iCache_byte;
        end
    end

    // Next-state and next-register values; rdy_in low holds everything.
    // NOTE: every output of this block gets a default first so no latch can be inferred.
    always_comb begin
        w_state_nxt     = r_state;
        w_word_addr_nxt = r_word_addr;
        w_cnt_nxt       = r_cnt;
        w_pend_nxt      = r_pend;
        w_lane_nxt      = r_lane;
        w_line_nxt      = r_line;
        w_ins_nxt       = r_ins;
        w_valid_nxt     = r_valid;
        w_wr_en         = 1'b0;

        if (rdy_in) begin
            w_pend_nxt  = 1'b0;
            w_valid_nxt = 1'b0;
            w_line_nxt  = w_line_merged;

            if (flush_in) begin
                // Abort whatever is in flight; a late byte is dropped with r_pend.
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 2'd0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        // r_valid high means this request was just answered.
                        if (bus.fetch2iCache_en && !r_valid) begin
                            if (w_hit) begin
                                w_valid_nxt = 1'b1;
                                w_ins_nxt   = r_data[w_lkp_index];
                            end else begin
                                w_word_addr_nxt = bus.fetch2iCache_address[ADDR_W-1:2];
                                w_cnt_nxt       = 2'd0;
                                w_state_nxt     = S_REQ;
                            end
                        end
                    end
                    S_REQ: begin
                        if (bus.mem2iCache_grant) begin
                            w_pend_nxt = 1'b1;
                            w_lane_nxt = r_cnt;
                            w_cnt_nxt  = r_cnt + 2'd1;
                            if (r_cnt == 2'd3) begin
                                w_state_nxt = S_WAIT;
                            end
                        end
                    end
                    S_WAIT: begin
                        // Last byte is in w_line_merged now: commit the line.
                        w_wr_en     = 1'b1;
                        w_ins_nxt   = w_line_merged;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = S_RESP;
                    end
                    S_RESP: begin
                        w_state_nxt = S_IDLE;
                    end
                    default: begin
                        w_state_nxt = S_IDLE;
                    end
                endcase
            end
        end
    end

    // FSM and datapath registers.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state     <= S_IDLE;
            r_word_addr <= '0;
            r_cnt       <= 2'd0;
            r_pend      <= 1'b0;
            r_lane      <= 2'd0;
            r_line      <= '0;
            r_ins       <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_word_addr <= w_word_addr_nxt;
            r_cnt       <= w_cnt_nxt;
            r_pend      <= w_pend_nxt;
            r_lane      <= w_lane_nxt;
            r_line      <= w_line_nxt;
            r_ins       <= w_ins_nxt;
            r_valid     <= w_valid_nxt;
        end
    end

    // Line valid bits: cleared by reset, set when a refill commits.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_vld <= '0;
        end else if (w_wr_en) begin
            r_vld[w_fill_index] <= 1'b1;
        end
    end

    // Tag and data storage written on refill commit.
    // NOTE: the storage arrays have no reset; the valid bits alone make stale contents harmless.
    always_ff @(posedge clk_in) begin
        if (w_wr_en) begin
            r_tag[w_fill_index]  <= w_fill_tag;
            r_data[w_fill_index] <= w_line_merged;
        end
    end

    assign w_req                  = (r_state == S_REQ);
    assign bus.iCache2mem_req     = w_req;
    assign bus.iCache2mem_addr    = w_req ? {r_word_addr, r_cnt} : '0;
    assign bus.iCache2fetch_ins   = r_ins;
    assign bus.iCache2fetch_valid = r_valid & ~(rdy_in & flush_in);
endmodule

// File: tb/tb_icache_responder.sv
// Self-checking bench for icache_responder: a cache/memory model predicts the
// outputs every cycle, and directed fetches pin latencies and words by hand.
module tb_icache_responder;
    logic clk_in   = 1'b0;
    logic rst_in   = 1'b1;
    logic rdy_in   = 1'b1;
    logic flush_in = 1'b0;

    icache_responder_if #(.ADDR_W(32)) bus ();

    icache_responder #(.INDEX_BITS(6), .ADDR_W(32)) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
        .flush_in (flush_in),
        .bus      (bus)
    );

    always #5 clk_in = ~clk_in;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Main memory image: 0x1000 holds 0x00000013, everything else a simple hash.
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        if (a[31:2] == 30'h0000_0400) return (a[1:0] == 2'd0) ? 8'h13 : 8'h00;
        return 8'(a[7:0] * 8'd7 + a[15:8] + 8'h31);
    endfunction

    function automatic logic [31:0] mem_word(input logic [29:0] w);
        return {mem_byte({w, 2'd3}), mem_byte({w, 2'd2}), mem_byte({w, 2'd1}), mem_byte({w, 2'd0})};
    endfunction

    // ---------------- memory controller ----------------
    logic        mr_pend     = 1'b0;
    logic        mr_last_rdy = 1'b1;
    logic [31:0] mr_addr     = '0;
    int          gidx        = 0;
    int          glen        = 0;
    logic [15:0] gpat        = '0;

    initial begin
        bus.mem2iCache_grant = 1'b0;
        bus.mem2iCache_byte  = 8'hEE;
        forever begin
            @(negedge clk_in);
            if (rst_in) begin
                mr_pend = 1'b0;
                gidx    = 0;
            end else if (rdy_in) begin
                mr_pend = bus.iCache2mem_req && bus.mem2iCache_grant;
                mr_addr = bus.iCache2mem_addr;
                if (bus.iCache2mem_req) gidx++;
                else gidx = 0;
            end
            mr_last_rdy = rdy_in;
        end
    end

    initial forever begin
        @(posedge clk_in);
        #1;
        if (mr_last_rdy) bus.mem2iCache_byte = mr_pend ? mem_byte(mr_addr) : 8'hEE;
        bus.mem2iCache_grant = bus.iCache2mem_req && ((gidx < glen) ? gpat[gidx] : 1'b1);
    end

    // ---------------- reference model and compare ----------------
    typedef enum {M_NONE, M_FILL, M_LAST} mphase_t;
    mphase_t     m_phase = M_NONE;
    logic        m_valid = 1'b0;
    logic        m_req   = 1'b0;
    logic [31:0] m_ins   = '0;
    logic [31:0] m_addr  = '0;
    logic [29:0] m_word  = '0;
    int          m_got   = 0;
    bit          c_vld  [64];
    logic [23:0] c_tag  [64];
    logic [31:0] c_data [64];

    initial forever begin
        logic        exp_v;
        logic        nv;
        logic [31:0] a;
        logic [5:0]  idx;
        @(negedge clk_in);
        if (rst_in) begin
            check("rst_valid", 32'(bus.iCache2fetch_valid), 32'h0);
            check("rst_req",   32'(bus.iCache2mem_req),     32'h0);
            check("rst_addr",  bus.iCache2mem_addr,         32'h0);
            m_phase = M_NONE;
            m_valid = 1'b0;
            m_req   = 1'b0;
            m_addr  = '0;
            foreach (c_vld[i]) c_vld[i] = 1'b0;
        end else begin
            exp_v = m_valid && !(rdy_in && flush_in);
            check("cmp_valid", 32'(bus.iCache2fetch_valid), 32'(exp_v));
            if (exp_v) check("cmp_ins", bus.iCache2fetch_ins, m_ins);
            check("cmp_req", 32'(bus.iCache2mem_req), 32'(m_req));
            if (m_req) check("cmp_mem_addr", bus.iCache2mem_addr, m_addr);

            if (rdy_in) begin
                nv = 1'b0;
                if (flush_in) begin
                    m_phase = M_NONE;
                    m_req   = 1'b0;
                end else begin
                    case (m_phase)
                        M_NONE: begin
                            if (bus.fetch2iCache_en && !m_valid) begin
                                a   = bus.fetch2iCache_address;
                                idx = a[7:2];
                                if (c_vld[idx] && c_tag[idx] == a[31:8]) begin
                                    nv    = 1'b1;
                                    m_ins = c_data[idx];
                                end else begin
                                    m_phase = M_FILL;
                                    m_word  = a[31:2];
                                    m_got   = 0;
                                    m_req   = 1'b1;
                                    m_addr  = {a[31:2], 2'b00};
                                end
                            end
                        end
                        M_FILL: begin
                            if (bus.mem2iCache_grant) begin
                                m_got++;
                                if (m_got == 4) begin
                                    m_req   = 1'b0;
                                    m_phase = M_LAST;
                                end else begin
                                    m_addr = {m_word, 2'b00} + 32'(m_got);
                                end
                            end
                        end
                        default: begin
                            nv                    = 1'b1;
                            m_ins                 = mem_word(m_word);
                            c_vld[m_word[5:0]]    = 1'b1;
                            c_tag[m_word[5:0]]    = m_word[29:6];
                            c_data[m_word[5:0]]   = m_ins;
                            m_phase               = M_NONE;
                        end
                    endcase
                end
                m_valid = nv;
            end
        end
    end

    // ---------------- fetch buffer ----------------
    task automatic fetch(input logic [31:0] a, output int lat, output logic [31:0] ins,
                         output int nreq, output logic [31:0] last_addr);
        bus.fetch2iCache_en      = 1'b1;
        bus.fetch2iCache_address = a;
        lat       = -1;
        ins       = '0;
        nreq      = 0;
        last_addr = '0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk_in);
            if (bus.iCache2mem_req) begin
                nreq++;
                last_addr = bus.iCache2mem_addr;
            end
            if (bus.iCache2fetch_valid) begin
                lat = n;
                ins = bus.iCache2fetch_ins;
                break;
            end
        end
        @(posedge clk_in);
        #1;
        bus.fetch2iCache_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish within time limit");
        $fatal(1);
    end

    initial begin
        int          lat;
        int          nreq;
        int          nval;
        logic [31:0] ins;
        logic [31:0] last;

        bus.fetch2iCache_en      = 1'b0;
        bus.fetch2iCache_address = '0;
        repeat (2) @(negedge clk_in);
        check("reset_valid", 32'(bus.iCache2fetch_valid), 32'h0);
        check("reset_ins",   bus.iCache2fetch_ins,        32'h0);
        check("reset_req",   32'(bus.iCache2mem_req),     32'h0);
        check("reset_addr",  bus.iCache2mem_addr,         32'h0);
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        @(posedge clk_in);
        #1;

        // Cold miss with grant every cycle.
        fetch(32'h0000_1000, lat, ins, nreq, last);
        check("t1_latency", 32'(lat), 32'd6);
        check("t1_ins", ins, 32'h0000_0013);
        check("t1_req_cycles", 32'(nreq), 32'd4);
        check("t1_last_addr", last, 32'h0000_1003);

        // Hit on the same word.
        fetch(32'h0000_1000, lat, ins, nreq, last);
        check("t2_latency", 32'(lat), 32'd1);
        check("t2_ins", ins, 32'h0000_0013);
        check("t2_req_cycles", 32'(nreq), 32'd0);

        // Conflict on index 0.
        fetch(32'h0000_1100, lat, ins, nreq, last);
        check("t3_conflict_latency", 32'(lat), 32'd6);
        check("t3_conflict_ins", ins, 32'h5750_4942);
        fetch(32'h0000_1000, lat, ins, nreq, last);
        check("t3_remiss_latency", 32'(lat), 32'd6);
        check("t3_remiss_ins", ins, 32'h0000_0013);

        // Grant pattern 1,0,0,1,1,0,1.
        gpat = 16'b0000_0000_0101_1001;
        glen = 7;
        fetch(32'h0000_3004, lat, ins, nreq, last);
        glen = 0;
        check("t4_latency", 32'(lat), 32'd9);
        check("t4_ins", ins, 32'h928B_847D);
        check("t4_req_cycles", 32'(nreq), 32'd7);
        check("t4_last_addr", last, 32'h0000_3007);

        // Flush wins over a same-cycle hit request.
        bus.fetch2iCache_en      = 1'b1;
        bus.fetch2iCache_address = 32'h0000_1000;
        flush_in                 = 1'b1;
        @(posedge clk_in);
        #1;
        bus.fetch2iCache_en = 1'b0;
        flush_in            = 1'b0;
        nval = 0;
        repeat (3) begin
            @(negedge clk_in);
            if (bus.iCache2fetch_valid) nval++;
        end
        check("t5_idle_flush_valids", 32'(nval), 32'd0);
        @(posedge clk_in);
        #1;

        // Flush after the second grant of a miss on 0x2000.
        bus.fetch2iCache_en      = 1'b1;
        bus.fetch2iCache_address = 32'h0000_2000;
        @(posedge clk_in);
        #1;
        @(posedge clk_in);
        #1;
        @(posedge clk_in);
        #1;
        flush_in = 1'b1;
        @(posedge clk_in);
        #1;
        flush_in            = 1'b0;
        bus.fetch2iCache_en = 1'b0;
        @(negedge clk_in);
        check("t5_req_dropped", 32'(bus.iCache2mem_req), 32'h0);
        nval = 0;
        repeat (4) begin
            @(negedge clk_in);
            if (bus.iCache2fetch_valid) nval++;
        end
        check("t5_flush_valids", 32'(nval), 32'd0);
        @(posedge clk_in);
        #1;
        fetch(32'h0000_2000, lat, ins, nreq, last);
        check("t5_refetch_latency", 32'(lat), 32'd6);
        check("t5_refetch_ins", ins, 32'h665F_5851);
        check("t5_refetch_req_cycles", 32'(nreq), 32'd4);

        // Reset in the middle of a refill.
        bus.fetch2iCache_en      = 1'b1;
        bus.fetch2iCache_address = 32'h0000_4000;
        @(posedge clk_in);
        #1;
        @(posedge clk_in);
        #1;
        rst_in              = 1'b1;
        bus.fetch2iCache_en = 1'b0;
        @(negedge clk_in);
        check("t6_rst_valid", 32'(bus.iCache2fetch_valid), 32'h0);
        check("t6_rst_ins",   bus.iCache2fetch_ins,        32'h0);
        check("t6_rst_req",   32'(bus.iCache2mem_req),     32'h0);
        check("t6_rst_addr",  bus.iCache2mem_addr,         32'h0);
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        fetch(32'h0000_1000, lat, ins, nreq, last);
        check("t6_post_reset_latency", 32'(lat), 32'd6);
        check("t6_post_reset_ins", ins, 32'h0000_0013);

        // Hit with rdy_in low for three cycles.
        fork
            fetch(32'h0000_1000, lat, ins, nreq, last);
            begin
                rdy_in = 1'b0;
                repeat (3) @(posedge clk_in);
                #1;
                rdy_in = 1'b1;
            end
        join
        check("t6_stalled_hit_latency", 32'(lat), 32'd4);
        check("t6_stalled_hit_ins", ins, 32'h0000_0013);

        // Top word of the address space: no carry out of the word.
        fetch(32'hFFFF_FFFC, lat, ins, nreq, last);
        check("t7_wrap_latency", 32'(lat), 32'd6);
        check("t7_wrap_ins", ins, 32'h2922_1B14);
        check("t7_wrap_last_addr", last, 32'hFFFF_FFFF);

        repeat (3) @(negedge clk_in);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
